mtr_drv_pwm: RTL and testbench

- Dual-channel motor drive PWM generator for the Knight; sits directly upstream of the physics model / H-bridge.
- Converts signed left/right wheel speed commands into complementary, non-overlapping PWM pairs (lftPWM1/2, rghtPWM1/2).
- Period is 2048 clocks, matching the 11-bit inverse-PWM measurement downstream.
- Duty is double-buffered, so a period never contains a glitch.

---
 rtl/mtr_drv_pwm.sv | 133 +++++++++++++
 tb/tb_mtr_drv_pwm.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mtr_drv_pwm.sv
// mtr_drv_pwm: dual-channel motor drive PWM generator.
//
// Turns signed left/right wheel speed commands into complementary,
// non-overlapping PWM pairs for the H-bridge. The period is 2048 clocks
// from a free-running 11-bit counter. Duty is double-buffered, so a new
// command only takes effect at the start of the next period.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   en         in   drive enable; 0 forces every PWM output low
//   lft_spd    in   [11:0] signed left wheel speed command
//   rght_spd   in   [11:0] signed right wheel speed command
//   lftPWM1    out  left forward drive
//   lftPWM2    out  left reverse drive
//   rghtPWM1   out  right forward drive
//   rghtPWM2   out  right reverse drive
//   prd_strt   out  one-clock pulse on the first output clock of a period
//   lft_duty   out  [10:0] active left duty (11'h400 = zero speed)
//   rght_duty  out  [10:0] active right duty
module mtr_drv_pwm #(
  parameter int NONOVERLAP = 32,   // dead-time in clocks, 0..255
  parameter int SAT        = 1023  // speed magnitude limit, 1..1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [11:0] lft_spd,
  input  logic [11:0] rght_spd,
  output logic        lftPWM1,
  output logic        lftPWM2,
  output logic        rghtPWM1,
  output logic        rghtPWM2,
  output logic        prd_strt,
  output logic [10:0] lft_duty,
  output logic [10:0] rght_duty
);

  localparam logic [11:0]        NO12     = 12'(NONOVERLAP);
  localparam logic signed [11:0] SAT_POS  = 12'(SAT);
  localparam logic signed [11:0] SAT_NEG  = -12'(SAT);
  localparam logic [10:0]        CNT_LAST = 11'h7ff;
  localparam logic [10:0]        DUTY_MID = 11'h400;

  // Clamp a signed speed to +/-SAT and offset it around mid-scale.
  // With SAT <= 1023 the result lies in 1..2047, so 11 bits never overflow.
  function automatic logic [10:0] duty_of(input logic [11:0] spd);
    logic signed [11:0] s;
    logic [11:0]        sum;
    if ($signed(spd) > SAT_POS) begin
      s = SAT_POS;
    end else if ($signed(spd) < SAT_NEG) begin
      s = SAT_NEG;
    end else begin
      s = $signed(spd);
    end
    sum = 12'h400 + $unsigned(s);
    return sum[10:0];
  endfunction

  logic [10:0] cnt_q,       cnt_d;
  logic [10:0] lft_duty_q,  lft_duty_d;
  logic [10:0] rght_duty_q, rght_duty_d;
  logic        lft_pwm1_q,  lft_pwm1_d;
  logic        lft_pwm2_q,  lft_pwm2_d;
  logic        rght_pwm1_q, rght_pwm1_d;
  logic        rght_pwm2_q, rght_pwm2_d;
  logic        prd_strt_q,  prd_strt_d;

  logic [11:0] cnt12_s;
  logic [11:0] lft_duty12_s;
  logic [11:0] rght_duty12_s;

  // Next-state logic: counter, duty double buffer and PWM decode.
  always_comb begin
    cnt_d = cnt_q + 11'd1;

    // Loading on the last count makes the new duty active exactly at cnt==0.
    if (cnt_q == CNT_LAST) begin
      lft_duty_d  = duty_of(lft_spd);
      rght_duty_d = duty_of(rght_spd);
    end else begin
      lft_duty_d  = lft_duty_q;
      rght_duty_d = rght_duty_q;
    end

    // 12-bit compares so duty+NONOVERLAP past 2047 simply never matches.
    cnt12_s       = {1'b0, cnt_q};
    lft_duty12_s  = {1'b0, lft_duty_q};
    rght_duty12_s = {1'b0, rght_duty_q};

    // PWM1 waits NONOVERLAP after the wrap; PWM2 waits NONOVERLAP after duty.
    lft_pwm1_d  = en & (cnt12_s >= NO12) & (cnt12_s < lft_duty12_s);
    lft_pwm2_d  = en & (cnt12_s >= (lft_duty12_s + NO12));
    rght_pwm1_d = en & (cnt12_s >= NO12) & (cnt12_s < rght_duty12_s);
    rght_pwm2_d = en & (cnt12_s >= (rght_duty12_s + NO12));

    // Registered alongside the outputs, so it flags the first output clock.
    prd_strt_d  = (cnt_q == 11'd0);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= 11'd0;
      lft_duty_q  <= DUTY_MID;
      rght_duty_q <= DUTY_MID;
      lft_pwm1_q  <= 1'b0;
      lft_pwm2_q  <= 1'b0;
      rght_pwm1_q <= 1'b0;
      rght_pwm2_q <= 1'b0;
      prd_strt_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      lft_duty_q  <= lft_duty_d;
      rght_duty_q <= rght_duty_d;
      lft_pwm1_q  <= lft_pwm1_d;
      lft_pwm2_q  <= lft_pwm2_d;
      rght_pwm1_q <= rght_pwm1_d;
      rght_pwm2_q <= rght_pwm2_d;
      prd_strt_q  <= prd_strt_d;
    end
  end

  assign lftPWM1   = lft_pwm1_q;
  assign lftPWM2   = lft_pwm2_q;
  assign rghtPWM1  = rght_pwm1_q;
  assign rghtPWM2  = rght_pwm2_q;
  assign prd_strt  = prd_strt_q;
  assign lft_duty  = lft_duty_q;
  assign rght_duty = rght_duty_q;

endmodule

// File: tb/tb_mtr_drv_pwm.sv
// Testbench for mtr_drv_pwm: randomized and directed stimulus, a reference
// model that predicts each clock's outputs into a queue, and a monitor that
// pops and compares every clock plus per-period high-time totals.
module tb_mtr_drv_pwm;

  localparam int NO   = 32;
  localparam int SATV = 1023;
  localparam int PRD  = 2048;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        en       = 1'b0;
  logic [11:0] lft_spd  = 12'd0;
  logic [11:0] rght_spd = 12'd0;
  logic        lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, prd_strt;
  logic [10:0] lft_duty, rght_duty;

  always #10 clk = ~clk;

  mtr_drv_pwm #(.NONOVERLAP(NO), .SAT(SATV)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .lft_spd(lft_spd), .rght_spd(rght_spd),
    .lftPWM1(lftPWM1), .lftPWM2(lftPWM2),
    .rghtPWM1(rghtPWM1), .rghtPWM2(rghtPWM2),
    .prd_strt(prd_strt), .lft_duty(lft_duty), .rght_duty(rght_duty)
  );

  typedef struct packed {
    logic        l1, l2, r1, r2, prd;
    logic [10:0] ld, rd;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   m_cnt  = 0;
  int   m_ld   = 1024;
  int   m_rd   = 1024;

  function automatic int clampi(input int v);
    if (v > SATV) return SATV;
    if (v < -SATV) return -SATV;
    return v;
  endfunction

  function automatic int duty_ref(input logic [11:0] s);
    int v;
    v = int'($signed(s));
    return 1024 + clampi(v);
  endfunction

  function automatic int maxz(input int v);
    return (v > 0) ? v : 0;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s t=%0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  // Reference model: one predicted entry per clock edge.
  initial begin : model
    exp_t e;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_cnt = 0; m_ld = 1024; m_rd = 1024;
        e = '0;
        e.ld = 11'h400; e.rd = 11'h400;
        q.delete();
        q.push_back(e);
      end else begin
        e.l1  = en && (m_cnt >= NO) && (m_cnt < m_ld);
        e.l2  = en && (m_cnt >= m_ld + NO);
        e.r1  = en && (m_cnt >= NO) && (m_cnt < m_rd);
        e.r2  = en && (m_cnt >= m_rd + NO);
        e.prd = (m_cnt == 0);
        if (m_cnt == PRD - 1) begin
          m_ld = duty_ref(lft_spd);
          m_rd = duty_ref(rght_spd);
        end
        e.ld  = 11'(m_ld);
        e.rd  = 11'(m_rd);
        m_cnt = (m_cnt + 1) % PRD;
        q.push_back(e);
      end
    end
  end

  // Monitor: per-clock scoreboard compare, overlap check, period totals.
  initial begin : monitor
    exp_t e, a;
    int   cl1, cl2, cr1, cr2, pl, pr;
    bit   have, dirty, en_prev;
    cl1 = 0; cl2 = 0; cr1 = 0; cr2 = 0; pl = 1024; pr = 1024;
    have = 1'b0; dirty = 1'b1; en_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) have = 1'b0;
      if (q.size() > 0) begin
        e = q.pop_front();
        a = {lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, prd_strt, lft_duty, rght_duty};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs t=%0t: got pwm=%b%b%b%b prd=%b ld=%0d rd=%0d expected pwm=%b%b%b%b prd=%b ld=%0d rd=%0d",
                   $time, a.l1, a.l2, a.r1, a.r2, a.prd, a.ld, a.rd,
                   e.l1, e.l2, e.r1, e.r2, e.prd, e.ld, e.rd);
        end
        if (e.prd) begin
          if (have && !dirty) begin
            chk("lft_pwm1_hi_clks",  cl1, maxz(pl - NO));
            chk("lft_pwm2_hi_clks",  cl2, maxz(PRD - pl - NO));
            chk("rght_pwm1_hi_clks", cr1, maxz(pr - NO));
            chk("rght_pwm2_hi_clks", cr2, maxz(PRD - pr - NO));
          end
          cl1 = 0; cl2 = 0; cr1 = 0; cr2 = 0;
          pl = int'(e.ld); pr = int'(e.rd);
          dirty = 1'b0; have = rst_n;
        end
        if (!en_prev) dirty = 1'b1;
        cl1 += int'(lftPWM1); cl2 += int'(lftPWM2);
        cr1 += int'(rghtPWM1); cr2 += int'(rghtPWM2);
      end
      chk("no_overlap", int'((lftPWM1 && lftPWM2) || (rghtPWM1 && rghtPWM2)), 0);
      en_prev = en;
    end
  end

  // Advance n clocks, leaving time just after the edge for driving inputs.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_cnt(input int target);
    int b;
    b = 0;
    while (m_cnt != target && b < 4096) begin
      step(1);
      b++;
    end
    chk("wait_cnt", m_cnt, target);
  endtask

  initial begin : stim
    int sel;
    logic [11:0] picks [7];
    picks[0] = 12'h7ff; picks[1] = 12'h800; picks[2] = 12'd1023;
    picks[3] = 12'(-1023); picks[4] = 12'd1024; picks[5] = 12'(-1024);
    picks[6] = 12'd0;

    // Reset held, then zero-speed drive.
    step(3);
    chk("rst_lft_duty", int'(lft_duty), 1024);
    chk("rst_prd_strt", int'(prd_strt), 0);
    rst_n = 1'b1;
    en    = 1'b1;
    step(3 * PRD + 10);

    // Full-scale forward left, full-scale reverse right (saturating).
    lft_spd  = 12'd2000;
    rght_spd = 12'(-2000);
    step(3 * PRD);

    // Mid-period change only takes effect at the next period.
    lft_spd = 12'd0; rght_spd = 12'd0;
    step(PRD);
    wait_cnt(1000);
    rght_spd = 12'd500;
    step(1);
    chk("rght_duty_held_a", int'(rght_duty), 1024);
    step(500);
    chk("rght_duty_held_b", int'(rght_duty), 1024);
    wait_cnt(1);
    chk("rght_duty_loaded", int'(rght_duty), 1524);
    step(3 * PRD);

    // Enable drop and partial-period resume.
    rght_spd = 12'd0;
    step(PRD);
    wait_cnt(500);
    en = 1'b0;
    step(1);
    chk("en_off_outputs", int'({lftPWM1, lftPWM2, rghtPWM1, rghtPWM2}), 0);
    wait_cnt(1500);
    en = 1'b1;
    step(1);
    chk("en_on_lftPWM2", int'(lftPWM2), 1);
    step(2 * PRD);

    // Asynchronous reset mid-period while lftPWM1 is high.
    wait_cnt(700);
    chk("pre_rst_lftPWM1", int'(lftPWM1), 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_outputs", int'({lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, prd_strt}), 0);
    chk("async_rst_rght_duty", int'(rght_duty), 1024);
    step(4);
    rst_n = 1'b1;
    step(1);
    chk("first_prd_strt", int'(prd_strt), 1);
    chk("post_rst_lft_duty", int'(lft_duty), 1024);
    step(2 * PRD);

    // Randomized commands and enable.
    for (int i = 0; i < 10; i++) begin
      sel = int'($urandom_range(0, 3));
      if (sel == 0) begin
        lft_spd  = 12'($urandom);
        rght_spd = 12'($urandom);
      end else if (sel == 1) begin
        lft_spd  = picks[$urandom_range(0, 6)];
        rght_spd = picks[$urandom_range(0, 6)];
      end else begin
        lft_spd  = 12'($signed(12'($urandom_range(0, 600))) - 12'sd300);
        rght_spd = 12'($signed(12'($urandom_range(0, 600))) - 12'sd300);
      end
      en = ($urandom_range(0, 4) != 0);
      step(int'($urandom_range(1, 3000)));
    end
    en       = 1'b1;
    lft_spd  = 12'($urandom);
    rght_spd = 12'd300;
    step(3 * PRD);

    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
